uart_rx_fifo: RTL and testbench

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

---
 rtl/uart_pkg.sv | 24 ++
 rtl/uart_fifo.sv | 59 +++++
 rtl/uart_rx_fifo.sv | 160 ++++++++++++++++
 tb/tb_uart_rx_fifo.sv | 202 ++++++++++++++++++++
 4 files changed

// File: rtl/uart_pkg.sv
// Shared encodings for the UART receive path: parity modes and receiver FSM states.
package uart_pkg;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_START,
    ST_DATA,
    ST_PAR,
    ST_STOP,
    ST_BREAK
  } state_t;

  // data_xor is the XOR-reduction of the received data bits.
  function automatic logic parity_bad(input int mode, input logic data_xor, input logic par_bit);
    logic x;
    x = data_xor ^ par_bit;
    return (mode == PAR_ODD) ? ~x : x;
  endfunction

endpackage

// File: rtl/uart_fifo.sv
// First-word fall-through receive FIFO; a pop on an empty FIFO is ignored,
// a push on a full FIFO is accepted only when a pop frees a slot in the same cycle.
module uart_fifo #(
  parameter int DATA_W     = 8,
  parameter int FIFO_DEPTH = 4
) (
  input  logic                               i_clk,
  input  logic                               i_reset,
  input  logic                               i_push,
  input  logic [DATA_W-1:0]                  i_wdata,
  input  logic                               i_pop,
  output logic [DATA_W-1:0]                  o_rdata,
  output logic                               o_empty,
  output logic                               o_full,
  output logic [$clog2(FIFO_DEPTH+1)-1:0]    o_count
);

  localparam int AW = $clog2(FIFO_DEPTH);
  localparam int CW = $clog2(FIFO_DEPTH+1);
  localparam logic [CW-1:0] FULL_CNT = CW'(FIFO_DEPTH);

  logic [DATA_W-1:0] mem_q [FIFO_DEPTH];
  logic [AW-1:0]     wr_ptr_q, rd_ptr_q;
  logic [CW-1:0]     count_q, count_d;
  logic              do_push, do_pop;

  assign o_empty = (count_q == '0);
  assign o_full  = (count_q == FULL_CNT);
  assign do_push = i_push && (!o_full || i_pop);
  assign do_pop  = i_pop && !o_empty;
  assign o_count = count_q;
  assign o_rdata = o_empty ? '0 : mem_q[rd_ptr_q];

  always_comb begin
    count_d = count_q;
    if (do_push && !do_pop)
      count_d = count_q + 1'b1;
    else if (do_pop && !do_push)
      count_d = count_q - 1'b1;
  end

  always_ff @(posedge i_clk) begin
    if (do_push)
      mem_q[wr_ptr_q] <= i_wdata;
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      count_q <= count_d;
    end
  end

endmodule

// File: rtl/uart_rx_fifo.sv
// UART receiver with mid-bit sampling, optional parity, 1-2 stop bits and a
// receive FIFO; errors and overruns are reported as one-cycle pulses.
//
// state | meaning
// IDLE  | line idle, waiting for rxs low
// START | counting to the middle of the start bit, then re-checking it
// DATA  | sampling DATA_W data bits, LSB first
// PAR   | sampling the parity bit (skipped when PARITY is none)
// STOP  | sampling STOP_BITS stop bits; good word pushed on exit
// BREAK | stop bit was low; waiting for the line to return high
module uart_rx_fifo
  import uart_pkg::*;
#(
  parameter int DATA_W       = 8,
  parameter int CLKS_PER_BIT = 8,
  parameter int PARITY       = 0,
  parameter int STOP_BITS    = 1,
  parameter int FIFO_DEPTH   = 4
) (
  input  logic                            i_clk,
  input  logic                            i_reset,
  input  logic                            i_datain,
  output logic [DATA_W-1:0]               o_dataout,
  output logic                            o_valid,
  input  logic                            i_ready,
  output logic                            o_parity_err,
  output logic                            o_frame_err,
  output logic                            o_overrun,
  output logic                            o_busy,
  output logic [$clog2(FIFO_DEPTH+1)-1:0] o_count
);

  localparam int TW = $clog2(CLKS_PER_BIT);
  localparam logic [TW-1:0] HALF_LOAD = TW'(CLKS_PER_BIT/2 - 1);
  localparam logic [TW-1:0] BIT_LOAD  = TW'(CLKS_PER_BIT - 1);
  localparam logic [3:0]    LAST_DATA = 4'(DATA_W - 1);
  localparam logic [3:0]    LAST_STOP = 4'(STOP_BITS - 1);

  state_t            state_q;
  logic [1:0]        sync_q;
  logic              rxs;
  logic [TW-1:0]     cnt_q;
  logic [3:0]        bit_q;
  logic [DATA_W-1:0] shift_q;
  logic              bad_q, push_q, perr_q, ferr_q, ovr_q;
  logic              fifo_empty, fifo_full, pop;

  assign rxs = sync_q[1];

  always_ff @(posedge i_clk) begin
    if (i_reset) sync_q <= 2'b11;
    else         sync_q <= {sync_q[0], i_datain};
  end

  always_ff @(posedge i_clk) begin
    if (i_reset) begin
      state_q <= ST_IDLE;
      cnt_q   <= '0;
      bit_q   <= '0;
      shift_q <= '0;
      bad_q   <= 1'b0;
      push_q  <= 1'b0;
      perr_q  <= 1'b0;
      ferr_q  <= 1'b0;
    end else begin
      push_q <= 1'b0;
      perr_q <= 1'b0;
      ferr_q <= 1'b0;
      unique case (state_q)
        ST_IDLE: begin
          if (!rxs) begin
            state_q <= ST_START;
            cnt_q   <= HALF_LOAD;
            bit_q   <= '0;
            bad_q   <= 1'b0;
          end
        end
        ST_START: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else if (rxs) state_q <= ST_IDLE;
          else begin
            state_q <= ST_DATA;
            cnt_q   <= BIT_LOAD;
          end
        end
        ST_DATA: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            shift_q <= {rxs, shift_q[DATA_W-1:1]};
            cnt_q   <= BIT_LOAD;
            if (bit_q == LAST_DATA) begin
              bit_q   <= '0;
              state_q <= (PARITY != PAR_NONE) ? ST_PAR : ST_STOP;
            end else begin
              bit_q <= bit_q + 1'b1;
            end
          end
        end
        ST_PAR: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else begin
            cnt_q   <= BIT_LOAD;
            state_q <= ST_STOP;
            if (parity_bad(PARITY, ^shift_q, rxs)) begin
              perr_q <= 1'b1;
              bad_q  <= 1'b1;
            end
          end
        end
        ST_STOP: begin
          if (cnt_q != '0) cnt_q <= cnt_q - 1'b1;
          else if (!rxs) begin
            ferr_q  <= 1'b1;
            bad_q   <= 1'b1;
            state_q <= ST_BREAK;
          end else if (bit_q == LAST_STOP) begin
            state_q <= ST_IDLE;
            push_q  <= !bad_q;
          end else begin
            bit_q <= bit_q + 1'b1;
            cnt_q <= BIT_LOAD;
          end
        end
        ST_BREAK: begin
          if (rxs) state_q <= ST_IDLE;
        end
        default: state_q <= ST_IDLE;
      endcase
    end
  end

  // Overrun is judged against the same full/pop view the FIFO uses to drop the word.
  always_ff @(posedge i_clk) begin
    if (i_reset) ovr_q <= 1'b0;
    else         ovr_q <= push_q && fifo_full && !pop;
  end

  assign pop          = o_valid && i_ready;
  assign o_valid      = !fifo_empty;
  assign o_busy       = (state_q != ST_IDLE);
  assign o_parity_err = perr_q;
  assign o_frame_err  = ferr_q;
  assign o_overrun    = ovr_q;

  uart_fifo #(
    .DATA_W     (DATA_W),
    .FIFO_DEPTH (FIFO_DEPTH)
  ) u_fifo (
    .i_clk   (i_clk),
    .i_reset (i_reset),
    .i_push  (push_q),
    .i_wdata (shift_q),
    .i_pop   (pop),
    .o_rdata (o_dataout),
    .o_empty (fifo_empty),
    .o_full  (fifo_full),
    .o_count (o_count)
  );

endmodule

// File: tb/tb_uart_rx_fifo.sv
// Directed bench for uart_rx_fifo: a default instance plus an even-parity instance,
// with expected words queued at send time and compared as the consumer pops them.
module tb_uart_rx_fifo;

  logic       clk = 1'b0;
  logic       rst;
  logic       rx_a, rx_b, rdy_a, rdy_b;
  logic [7:0] dout_a, dout_b;
  logic       valid_a, valid_b, perr_a, perr_b, ferr_a, ferr_b;
  logic       ovr_a, ovr_b, busy_a, busy_b;
  logic [2:0] count_a, count_b;

  int n_assert = 0;
  int n_fail   = 0;
  int perr_a_n = 0, perr_b_n = 0, ferr_a_n = 0, ferr_b_n = 0, ovr_a_n = 0, ovr_b_n = 0;
  logic [7:0] exp_a[$];
  logic [7:0] exp_b[$];

  always #5 clk = ~clk;

  uart_rx_fifo u_dut (
    .i_clk(clk), .i_reset(rst), .i_datain(rx_a), .o_dataout(dout_a), .o_valid(valid_a),
    .i_ready(rdy_a), .o_parity_err(perr_a), .o_frame_err(ferr_a), .o_overrun(ovr_a),
    .o_busy(busy_a), .o_count(count_a)
  );

  uart_rx_fifo #(.PARITY(1)) u_par (
    .i_clk(clk), .i_reset(rst), .i_datain(rx_b), .o_dataout(dout_b), .o_valid(valid_b),
    .i_ready(rdy_b), .o_parity_err(perr_b), .o_frame_err(ferr_b), .o_overrun(ovr_b),
    .o_busy(busy_b), .o_count(count_b)
  );

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  always @(negedge clk) begin
    if (perr_a) perr_a_n++;
    if (perr_b) perr_b_n++;
    if (ferr_a) ferr_a_n++;
    if (ferr_b) ferr_b_n++;
    if (ovr_a)  ovr_a_n++;
    if (ovr_b)  ovr_b_n++;
    if (valid_a && rdy_a) begin
      check("pop_a_expected", 32'(exp_a.size() != 0), 1);
      if (exp_a.size() != 0) check("pop_a_data", dout_a, exp_a.pop_front());
    end
    if (valid_b && rdy_b) begin
      check("pop_b_expected", 32'(exp_b.size() != 0), 1);
      if (exp_b.size() != 0) check("pop_b_data", dout_b, exp_b.pop_front());
    end
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic drive(input bit which, input logic v);
    if (which) rx_b = v;
    else       rx_a = v;
  endtask

  task automatic send_bit(input bit which, input logic v, input int n);
    drive(which, v);
    tick(n);
  endtask

  task automatic send_frame(input bit which, input logic [7:0] d, input bit use_par,
                            input bit par_bit, input bit stop_bit);
    send_bit(which, 1'b0, 8);
    for (int i = 0; i < 8; i++) send_bit(which, d[i], 8);
    if (use_par) send_bit(which, par_bit, 8);
    send_bit(which, stop_bit, 8);
  endtask

  initial begin
    rx_a = 1'b1; rx_b = 1'b1; rdy_a = 1'b1; rdy_b = 1'b1; rst = 1'b1;
    tick(5);
    check("rst_valid", valid_a, 0);
    check("rst_busy", busy_a, 0);
    check("rst_count", count_a, 0);
    check("rst_dout", dout_a, 0);
    rst = 1'b0;
    tick(2);
    check("post_rst_valid", valid_a, 0);
    check("post_rst_busy", busy_a, 0);

    // Basic frame held in the FIFO, then popped
    rdy_a = 1'b0;
    exp_a.push_back(8'hDA);
    send_frame(0, 8'hDA, 0, 0, 1);
    tick(4);
    check("frame_count", count_a, 1);
    check("frame_valid", valid_a, 1);
    check("frame_dout", dout_a, 8'hDA);
    check("frame_perr", perr_a_n, 0);
    check("frame_ferr", ferr_a_n, 0);
    check("frame_ovr", ovr_a_n, 0);
    rdy_a = 1'b1;
    tick(3);
    check("frame_drained", exp_a.size(), 0);
    check("frame_count_0", count_a, 0);

    // Three-cycle glitch: false start
    drive(0, 1'b0);
    tick(3);
    drive(0, 1'b1);
    tick(1);
    check("glitch_busy_hi", busy_a, 1);
    tick(3);
    check("glitch_busy_lo", busy_a, 0);
    tick(10);
    check("glitch_count", count_a, 0);
    check("glitch_valid", valid_a, 0);

    // Even parity: 0x01 with parity 0 is bad, 0x03 with parity 0 is good
    send_frame(1, 8'h01, 1, 0, 1);
    tick(4);
    check("par_err_n", perr_b_n, 1);
    check("par_count", count_b, 0);
    check("par_valid", valid_b, 0);
    check("par_ferr", ferr_b_n, 0);
    exp_b.push_back(8'h03);
    send_frame(1, 8'h03, 1, 0, 1);
    tick(4);
    check("par_good_err_n", perr_b_n, 1);
    check("par_good_drained", exp_b.size(), 0);

    // Low stop bit, line held low 30 cycles
    send_frame(0, 8'h5A, 0, 0, 0);
    tick(22);
    check("brk_state", 32'(u_dut.state_q), 32'(uart_pkg::ST_BREAK));
    check("brk_busy", busy_a, 1);
    check("brk_ferr_n", ferr_a_n, 1);
    drive(0, 1'b1);
    tick(4);
    check("brk_busy_lo", busy_a, 0);
    check("brk_count", count_a, 0);
    check("brk_ferr_once", ferr_a_n, 1);

    // Fill and overrun
    rdy_a = 1'b0;
    for (int i = 1; i <= 5; i++) begin
      logic [7:0] d;
      d = 8'(i * 17);
      if (i <= 4) exp_a.push_back(d);
      send_frame(0, d, 0, 0, 1);
      tick(3);
      if (i == 4) begin
        check("fill_count4", count_a, 4);
        check("fill_no_ovr", ovr_a_n, 0);
      end
    end
    check("ovr_count", count_a, 4);
    check("ovr_pulse_n", ovr_a_n, 1);
    check("ovr_head", dout_a, 8'h11);
    rdy_a = 1'b1;
    tick(8);
    check("ovr_drained", exp_a.size(), 0);
    check("ovr_count_0", count_a, 0);

    // Reset during data bit 3 also empties the FIFO
    rdy_a = 1'b0;
    exp_a.push_back(8'h3C);
    send_frame(0, 8'h3C, 0, 0, 1);
    tick(3);
    check("pre_rst_count", count_a, 1);
    send_bit(0, 1'b0, 8);
    send_bit(0, 1'b0, 8);
    send_bit(0, 1'b1, 8);
    send_bit(0, 1'b0, 8);
    send_bit(0, 1'b0, 4);
    rst = 1'b1;
    exp_a.delete();
    tick(2);
    rst = 1'b0;
    drive(0, 1'b1);
    tick(20);
    check("midrst_count", count_a, 0);
    check("midrst_valid", valid_a, 0);
    check("midrst_dout", dout_a, 0);
    check("midrst_busy", busy_a, 0);
    check("midrst_ferr", ferr_a_n, 1);
    check("midrst_perr", perr_a_n, 0);
    rdy_a = 1'b1;
    exp_a.push_back(8'hA5);
    send_frame(0, 8'hA5, 0, 0, 1);
    tick(4);
    check("after_rst_drained", exp_a.size(), 0);
    check("after_rst_count", count_a, 0);
    check("final_ovr_n", ovr_a_n, 1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
